// File: rtl/timer_a_prescaler_pkg.sv
// Shared TimerA field encodings (TASSEL__, ID__, MC__) and the IDEX width.
// Used by the prescaler top and by any other TimerA stage that decodes these fields.
package timer_a_prescaler_pkg;

  localparam int IDEX_WIDTH = 3;

  localparam logic [1:0] TASSEL__TACLK = 2'b00;
  localparam logic [1:0] TASSEL__ACLK  = 2'b01;
  localparam logic [1:0] TASSEL__SMCLK = 2'b10;
  localparam logic [1:0] TASSEL__INCLK = 2'b11;

  localparam logic [1:0] ID__DIV1 = 2'b00;
  localparam logic [1:0] ID__DIV2 = 2'b01;
  localparam logic [1:0] ID__DIV4 = 2'b10;
  localparam logic [1:0] ID__DIV8 = 2'b11;

  localparam logic [1:0] MC__STOP   = 2'b00;
  localparam logic [1:0] MC__UP     = 2'b01;
  localparam logic [1:0] MC__CONT   = 2'b10;
  localparam logic [1:0] MC__UPDOWN = 2'b11;

  // Terminal value of the input-divider counter, (1<<ID)-1.
  function automatic logic [2:0] idTerminal(input logic [1:0] id);
    logic [2:0] term;
    case (id)
      ID__DIV1: term = 3'd0;
      ID__DIV2: term = 3'd1;
      ID__DIV4: term = 3'd3;
      default:  term = 3'd7;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/timer_a_prescaler_edge_sync.sv
// Two-flop synchronizer plus history bit for one asynchronous timer source.
// Emits a one-MCLK-cycle pulse on each synchronized rising edge.
module timer_a_edge_sync (
  input  logic MCLK,
  input  logic reset_n,
  input  logic source,
  output logic risingEdge
);

  logic sync1;
  logic sync2;
  logic history;

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      history <= 1'b0;
    end else begin
      sync1   <= source;
      sync2   <= sync1;
      history <= sync2;
    end
  end

  assign risingEdge = sync2 & ~history;

endmodule

// File: rtl/timer_a_prescaler.sv
// TimerA clock prescaler: source edge select, /1../8 input divider and optional
// /1../8 expansion divider (macro TIMERA_IDEX_EN), producing a count-enable tick.
module timer_a_prescaler
  import timer_a_prescaler_pkg::*;
(
  input  logic                  MCLK,
  input  logic                  reset_n,
  input  logic                  TACLK,
  input  logic                  ACLK,
  input  logic                  SMCLK,
  input  logic                  INCLK,
  input  logic [1:0]            TASSEL,
  input  logic [1:0]            ID,
  input  logic [IDEX_WIDTH-1:0] IDEX,
  input  logic [1:0]            MC,
  input  logic                  wTACLR,
  output logic                  TimerTick
);

  logic edgeTaclk;
  logic edgeAclk;
  logic edgeSmclk;
  logic edgeInclk;
  logic selEdge;
  logic countEnable;
  logic idDone;
  logic idexDone;
  logic [2:0] idCnt;

  // Every source is synchronized all the time so switching TASSEL never sees a stale edge.
  timer_a_edge_sync uSyncTaclk (.MCLK(MCLK), .reset_n(reset_n), .source(TACLK), .risingEdge(edgeTaclk));
  timer_a_edge_sync uSyncAclk  (.MCLK(MCLK), .reset_n(reset_n), .source(ACLK),  .risingEdge(edgeAclk));
  timer_a_edge_sync uSyncSmclk (.MCLK(MCLK), .reset_n(reset_n), .source(SMCLK), .risingEdge(edgeSmclk));
  timer_a_edge_sync uSyncInclk (.MCLK(MCLK), .reset_n(reset_n), .source(INCLK), .risingEdge(edgeInclk));

  always_comb begin
    selEdge = 1'b0;
    case (TASSEL)
      TASSEL__TACLK: selEdge = edgeTaclk;
      TASSEL__ACLK:  selEdge = edgeAclk;
      TASSEL__SMCLK: selEdge = edgeSmclk;
      default:       selEdge = edgeInclk;
    endcase
  end

  assign countEnable = selEdge && (MC != MC__STOP);
  assign idDone      = (idCnt >= idTerminal(ID));

`ifdef TIMERA_IDEX_EN
  logic [IDEX_WIDTH-1:0] idexCnt;

  assign idexDone = (idexCnt >= IDEX);

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      idexCnt <= '0;
    end else if (wTACLR) begin
      idexCnt <= '0;
    end else if (countEnable && idDone) begin
      idexCnt <= idexDone ? '0 : idexCnt + 1'b1;
    end
  end
`else
  logic unusedIdex;

  assign unusedIdex = ^IDEX;
  assign idexDone   = 1'b1;
`endif

  // The ">=" compares let a reduced ID/IDEX take effect on the very next edge.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      idCnt     <= 3'd0;
      TimerTick <= 1'b0;
    end else if (wTACLR) begin
      idCnt     <= 3'd0;
      TimerTick <= 1'b0;
    end else begin
      TimerTick <= countEnable && idDone && idexDone;
      if (countEnable) begin
        idCnt <= idDone ? 3'd0 : idCnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_timer_a_prescaler.sv
// Self-checking bench for timer_a_prescaler; expectations come from the
// division-ratio rule (tick on every ratio-th qualifying edge) plus directed cases.
module tb_timer_a_prescaler;
  import timer_a_prescaler_pkg::*;

`ifdef TIMERA_IDEX_EN
  localparam bit IdexEnabled = 1'b1;
`else
  localparam bit IdexEnabled = 1'b0;
`endif

  logic       MCLK = 1'b0;
  logic       reset_n;
  logic [3:0] srcs;
  logic [1:0] TASSEL;
  logic [1:0] ID;
  logic [2:0] IDEX;
  logic [1:0] MC;
  logic       wTACLR;
  logic       TimerTick;

  int checks    = 0;
  int errors    = 0;
  int tickCount = 0;

  always #5 MCLK = ~MCLK;

  timer_a_prescaler dut (
    .MCLK(MCLK), .reset_n(reset_n),
    .TACLK(srcs[0]), .ACLK(srcs[1]), .SMCLK(srcs[2]), .INCLK(srcs[3]),
    .TASSEL(TASSEL), .ID(ID), .IDEX(IDEX), .MC(MC),
    .wTACLR(wTACLR), .TimerTick(TimerTick)
  );

  always @(negedge MCLK) begin
    if (TimerTick === 1'b1) tickCount++;
  end

  function automatic int ratioOf(input logic [1:0] id, input logic [2:0] idex);
    return (1 << id) * ((IdexEnabled ? int'(idex) : 0) + 1);
  endfunction

  // One rising edge on source sel; optionally clear coincident with the edge.
  task automatic doEdge(input int sel, input logic exp, input logic clr, input string name);
    @(negedge MCLK); srcs[sel] = 1'b1;
    @(posedge MCLK);
    @(posedge MCLK);
    @(negedge MCLK); wTACLR = clr;
    @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== exp) begin
      errors++;
      $display("[TB] FAIL %s: TimerTick=%0b expected %0b", name, TimerTick, exp);
    end
    @(negedge MCLK); wTACLR = 1'b0;
    @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_width: TimerTick=%0b expected 0", name, TimerTick);
    end
    @(negedge MCLK); srcs[sel] = 1'b0;
    repeat (4) @(posedge MCLK);
  endtask

  task automatic clearCounters();
    @(negedge MCLK); wTACLR = 1'b1;
    @(negedge MCLK); wTACLR = 1'b0;
  endtask

  task automatic checkTickDelta(input int start, input int exp, input string name);
    checks++;
    if (tickCount - start !== exp) begin
      errors++;
      $display("[TB] FAIL %s: ticks=%0d expected %0d", name, tickCount - start, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; srcs = 4'b0; TASSEL = TASSEL__ACLK; ID = ID__DIV1;
    IDEX = 3'd0; MC = MC__UP; wTACLR = 1'b0;
    repeat (3) @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_tick: TimerTick=%0b expected 0", TimerTick);
    end
    @(negedge MCLK); srcs[1] = 1'b1;
    repeat (3) @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_hold: TimerTick=%0b expected 0", TimerTick);
    end
    @(negedge MCLK); reset_n = 1'b1;
    @(posedge MCLK); @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== 1'b0) begin
      errors++; $display("[TB] FAIL release_fill: TimerTick=%0b expected 0", TimerTick);
    end
    @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== 1'b1) begin
      errors++; $display("[TB] FAIL release_edge: TimerTick=%0b expected 1", TimerTick);
    end
    @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== 1'b0) begin
      errors++; $display("[TB] FAIL release_single: TimerTick=%0b expected 0", TimerTick);
    end
    @(negedge MCLK); srcs[1] = 1'b0;
    repeat (4) @(posedge MCLK);
  endtask

  task automatic test_aclk_div1();
    int start;
    TASSEL = TASSEL__ACLK; ID = ID__DIV1; IDEX = 3'd0; MC = MC__UP;
    clearCounters();
    start = tickCount;
    for (int k = 1; k <= 6; k++) doEdge(1, 1'b1, 1'b0, $sformatf("div1_edge%0d", k));
    checkTickDelta(start, 6, "div1_count");
  endtask

  task automatic test_div64();
    int start;
    int r;
    TASSEL = TASSEL__SMCLK; ID = ID__DIV8; IDEX = 3'd7; MC = MC__CONT;
    r = ratioOf(ID, IDEX);
    clearCounters();
    start = tickCount;
    for (int k = 1; k <= 640; k++)
      doEdge(2, (k % r) == 0, 1'b0, $sformatf("div64_edge%0d", k));
    checkTickDelta(start, 640 / r, "div64_count");
  endtask

  task automatic test_stop();
    int start;
    TASSEL = TASSEL__TACLK; ID = ID__DIV2; IDEX = 3'd0; MC = MC__UP;
    clearCounters();
    doEdge(0, 1'b0, 1'b0, "stop_pre1");
    doEdge(0, 1'b1, 1'b0, "stop_pre2");
    doEdge(0, 1'b0, 1'b0, "stop_pre3");
    @(negedge MCLK); MC = MC__STOP;
    start = tickCount;
    for (int k = 1; k <= 5; k++) doEdge(0, 1'b0, 1'b0, $sformatf("stopped_edge%0d", k));
    checkTickDelta(start, 0, "stopped_count");
    @(negedge MCLK); MC = MC__UP;
    doEdge(0, 1'b1, 1'b0, "stop_resume");
  endtask

  task automatic test_clear();
    TASSEL = TASSEL__INCLK; ID = ID__DIV4; IDEX = 3'd0; MC = MC__UPDOWN;
    clearCounters();
    for (int k = 1; k <= 3; k++) doEdge(3, 1'b0, 1'b0, $sformatf("clr_pre%0d", k));
    clearCounters();
    doEdge(3, 1'b0, 1'b1, "clr_coincident");
    for (int k = 1; k <= 4; k++)
      doEdge(3, k == 4, 1'b0, $sformatf("clr_post%0d", k));
  endtask

  task automatic test_tassel_switch();
    int start;
    MC = MC__STOP; ID = ID__DIV1; IDEX = 3'd0; TASSEL = TASSEL__TACLK;
    @(negedge MCLK); srcs[0] = 1'b1; srcs[1] = 1'b1;
    repeat (6) @(posedge MCLK);
    @(negedge MCLK); MC = MC__UP;
    start = tickCount;
    for (int k = 0; k < 12; k++) begin
      @(negedge MCLK); TASSEL = (k % 2 == 0) ? TASSEL__ACLK : TASSEL__TACLK;
      repeat (3) @(posedge MCLK);
    end
    @(negedge MCLK);
    checkTickDelta(start, 0, "tassel_switch");
    MC = MC__STOP; srcs[0] = 1'b0; srcs[1] = 1'b0;
    repeat (6) @(posedge MCLK);
    MC = MC__UP;
  endtask

  task automatic test_mid_change();
    TASSEL = TASSEL__TACLK; ID = ID__DIV8; IDEX = 3'd0; MC = MC__UP;
    clearCounters();
    for (int k = 1; k <= 6; k++) doEdge(0, 1'b0, 1'b0, $sformatf("mid_pre%0d", k));
    @(negedge MCLK); ID = ID__DIV2;
    doEdge(0, 1'b1, 1'b0, "mid_reduce");
    @(negedge MCLK); ID = ID__DIV8;
    for (int k = 1; k <= 3; k++) doEdge(0, 1'b0, 1'b0, $sformatf("mid_partial%0d", k));
    @(negedge MCLK); reset_n = 1'b0;
    @(posedge MCLK); #1;
    checks++;
    if (TimerTick !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: TimerTick=%0b expected 0", TimerTick);
    end
    @(negedge MCLK); reset_n = 1'b1; ID = ID__DIV2;
    doEdge(0, 1'b0, 1'b0, "restart_edge1");
    doEdge(0, 1'b1, 1'b0, "restart_edge2");
  endtask

  task automatic test_random();
    int sel;
    int r;
    int n;
    int start;
    logic [3:0] noise;
    for (int it = 0; it < 20; it++) begin
      sel    = $urandom_range(0, 3);
      TASSEL = 2'(sel);
      ID     = 2'($urandom_range(0, 3));
      IDEX   = 3'($urandom_range(0, 7));
      MC     = 2'($urandom_range(1, 3));
      r      = ratioOf(ID, IDEX);
      n      = r + $urandom_range(0, 8);
      clearCounters();
      start = tickCount;
      for (int k = 1; k <= n; k++) begin
        @(negedge MCLK);
        noise = 4'($urandom);
        noise[sel] = 1'b0;
        srcs = noise;
        doEdge(sel, (k % r) == 0, 1'b0, $sformatf("rand%0d_edge%0d", it, k));
      end
      @(negedge MCLK); srcs = 4'b0;
      repeat (4) @(posedge MCLK);
      @(negedge MCLK);
      checkTickDelta(start, n / r, $sformatf("rand%0d_count", it));
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_aclk_div1();
    test_div64();
    test_stop();
    test_clear();
    test_tassel_switch();
    test_mid_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
